// File: rtl/chunk_scheduler_pkg.sv
// ============================================================================
// chunk_scheduler_pkg
// Shared audio definitions: scheduler state encoding and default sizes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package chunk_scheduler_pkg;

  localparam int DEFAULT_IO_BUFF_SIZE = 64;
  localparam int CHUNK_CNT_BITS       = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter
// Up counter that sticks at all-ones; synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/chunk_scheduler.sv
// ============================================================================
// chunk_scheduler
// Ping-pong bank scheduler between the codec sample stream and a chunk processor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunk_scheduler
  import chunk_scheduler_pkg::*;
#(
  parameter int IO_BUFF_SIZE     = DEFAULT_IO_BUFF_SIZE,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
  parameter int DROP_CNT_BITS    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        sample_strobe,
  output logic [IO_BUFF_PTR_BITS-1:0] io_ptr,
  output logic                        io_bank,
  output logic                        proc_bank,
  output logic                        chunk_pulse,
  input  logic                        proc_done,
  output logic                        proc_busy,
  output logic                        overrun,
  input  logic                        overrun_clear,
  output logic [CHUNK_CNT_BITS-1:0]   chunk_count,
  output logic [DROP_CNT_BITS-1:0]    drop_count
);

  localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

  sched_state_t                state, state_nxt;
  logic [IO_BUFF_PTR_BITS-1:0] ptr_nxt;
  logic                        bank_nxt;
  logic                        pulse_nxt;
  logic                        busy_eff;
  logic                        busy_nxt;
  logic                        overrun_set;
  logic                        overrun_nxt;
  logic [CHUNK_CNT_BITS-1:0]   count_nxt;
  logic                        drop_inc;
  logic                        boundary;

  assign boundary = sample_strobe && (io_ptr == PTR_LAST);
  // A completion arriving with a boundary frees the processor before the boundary is judged.
  assign busy_eff = proc_busy & ~proc_done;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = io_ptr;
    bank_nxt    = io_bank;
    pulse_nxt   = 1'b0;
    busy_nxt    = busy_eff;
    overrun_set = 1'b0;
    count_nxt   = chunk_count;
    drop_inc    = 1'b0;

    if (!enable) begin
      state_nxt = ST_IDLE;
      ptr_nxt   = '0;
      bank_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_PRIME;
        ST_PRIME, ST_STREAM: begin
          if (sample_strobe) begin
            ptr_nxt = boundary ? '0 : io_ptr + 1'b1;
            if (boundary) begin
              bank_nxt = ~io_bank;
              if (state == ST_PRIME) begin
                state_nxt = ST_STREAM;
              end else if (!busy_eff) begin
                pulse_nxt = 1'b1;
                busy_nxt  = 1'b1;
                count_nxt = chunk_count + CHUNK_CNT_BITS'(1);
              end else begin
                // Drop the chunk but keep toggling so the codec never stalls.
                overrun_set = 1'b1;
                drop_inc    = 1'b1;
              end
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    overrun_nxt = overrun_set | (overrun & ~overrun_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      io_ptr      <= '0;
      io_bank     <= 1'b0;
      proc_bank   <= 1'b1;
      chunk_pulse <= 1'b0;
      proc_busy   <= 1'b0;
      overrun     <= 1'b0;
      chunk_count <= '0;
    end else begin
      state       <= state_nxt;
      io_ptr      <= ptr_nxt;
      io_bank     <= bank_nxt;
      proc_bank   <= ~bank_nxt;
      chunk_pulse <= pulse_nxt;
      proc_busy   <= busy_nxt;
      overrun     <= overrun_nxt;
      chunk_count <= count_nxt;
    end
  end

  sat_counter #(
    .WIDTH(DROP_CNT_BITS)
  ) u_drop_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (drop_inc),
    .clr  (1'b0),
    .count(drop_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_chunk_scheduler.sv
// ============================================================================
// tb_chunk_scheduler
// Directed scenarios plus randomized traffic against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_chunk_scheduler;

  localparam int SIZE     = 8;
  localparam int PW       = 3;
  localparam int DW       = 3;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          sample_strobe = 1'b0;
  logic [PW-1:0] io_ptr;
  logic          io_bank;
  logic          proc_bank;
  logic          chunk_pulse;
  logic          proc_done = 1'b0;
  logic          proc_busy;
  logic          overrun;
  logic          overrun_clear = 1'b0;
  logic [15:0]   chunk_count;
  logic [DW-1:0] drop_count;

  chunk_scheduler #(
    .IO_BUFF_SIZE    (SIZE),
    .IO_BUFF_PTR_BITS(PW),
    .DROP_CNT_BITS   (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_strobe(sample_strobe),
    .io_ptr       (io_ptr),
    .io_bank      (io_bank),
    .proc_bank    (proc_bank),
    .chunk_pulse  (chunk_pulse),
    .proc_done    (proc_done),
    .proc_busy    (proc_busy),
    .overrun      (overrun),
    .overrun_clear(overrun_clear),
    .chunk_count  (chunk_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0=idle, 1=priming, 2=streaming
  int m_mode = 0, m_ptr = 0, m_bank = 0, m_busy = 0, m_ovr = 0;
  int m_cc = 0, m_dc = 0, m_pulse = 0;

  int pulses_seen = 0;
  int pulse_bank  = -1;

  task automatic model_step(input bit r, input bit en, input bit st, input bit dn, input bit oc);
    bit set_ovr;
    set_ovr = 1'b0;
    if (r) begin
      m_mode = 0; m_ptr = 0; m_bank = 0; m_busy = 0;
      m_ovr = 0; m_cc = 0; m_dc = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (dn) m_busy = 0;
      if (!en) begin
        m_mode = 0; m_ptr = 0; m_bank = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (st) begin
        m_ptr = (m_ptr + 1) % SIZE;
        if (m_ptr == 0) begin
          m_bank = 1 - m_bank;
          if (m_mode == 1) m_mode = 2;
          else if (m_busy == 0) begin
            m_pulse = 1; m_busy = 1; m_cc = (m_cc + 1) % 65536;
          end else begin
            set_ovr = 1'b1;
            if (m_dc < DROP_MAX) m_dc++;
          end
        end
      end
      if (set_ovr) m_ovr = 1;
      else if (oc) m_ovr = 0;
    end
  endtask

  task automatic tick(input bit r, input bit en, input bit st, input bit dn, input bit oc);
    rst = r; enable = en; sample_strobe = st; proc_done = dn; overrun_clear = oc;
    @(posedge clk);
    model_step(r, en, st, dn, oc);
    #1;
    if (chunk_pulse === 1'b1) begin
      pulses_seen++;
      pulse_bank = int'(io_bank);
    end
  endtask

  task automatic strobe_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick(0, 1, 1, 0, 0);
      tick(0, 1, 0, 0, 0);
    end
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 0);
    checks++; if (io_ptr !== '0) begin errors++; $display("FAIL reset io_ptr got %0d exp 0", io_ptr); end
    checks++; if (io_bank !== 1'b0) begin errors++; $display("FAIL reset io_bank got %b exp 0", io_bank); end
    checks++; if (proc_bank !== 1'b1) begin errors++; $display("FAIL reset proc_bank got %b exp 1", proc_bank); end
    checks++; if (chunk_pulse !== 1'b0) begin errors++; $display("FAIL reset chunk_pulse got %b exp 0", chunk_pulse); end
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL reset proc_busy got %b exp 0", proc_busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got %b exp 0", overrun); end
    checks++; if (chunk_count !== 16'd0) begin errors++; $display("FAIL reset chunk_count got %0d exp 0", chunk_count); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset drop_count got %0d exp 0", drop_count); end
  endtask

  task automatic test_first_chunk;
    tick(0, 1, 0, 0, 0);
    pulses_seen = 0;
    strobe_n(SIZE);
    checks++; if (io_bank !== 1'b1) begin errors++; $display("FAIL prime io_bank got %b exp 1", io_bank); end
    checks++; if (io_ptr !== '0) begin errors++; $display("FAIL prime io_ptr got %0d exp 0", io_ptr); end
    checks++; if (pulses_seen != 0) begin errors++; $display("FAIL prime pulses got %0d exp 0", pulses_seen); end
    strobe_n(SIZE);
    checks++; if (pulses_seen != 1) begin errors++; $display("FAIL first_chunk pulses got %0d exp 1", pulses_seen); end
    checks++; if (pulse_bank != 0) begin errors++; $display("FAIL first_chunk pulse_bank got %0d exp 0", pulse_bank); end
    checks++; if (chunk_count !== 16'd1) begin errors++; $display("FAIL first_chunk chunk_count got %0d exp 1", chunk_count); end
    checks++; if (proc_busy !== 1'b1) begin errors++; $display("FAIL first_chunk proc_busy got %b exp 1", proc_busy); end
  endtask

  task automatic test_done_then_chunk;
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 0);
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL done busy got %b exp 0", proc_busy); end
    pulses_seen = 0;
    strobe_n(SIZE);
    checks++; if (pulses_seen != 1) begin errors++; $display("FAIL done_chunk pulses got %0d exp 1", pulses_seen); end
    checks++; if (chunk_count !== 16'd2) begin errors++; $display("FAIL done_chunk chunk_count got %0d exp 2", chunk_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL done_chunk overrun got %b exp 0", overrun); end
    checks++; if (proc_bank !== ~io_bank) begin errors++; $display("FAIL done_chunk proc_bank got %b exp %b", proc_bank, ~io_bank); end
  endtask

  task automatic test_overrun;
    logic b0;
    b0 = io_bank;
    pulses_seen = 0;
    strobe_n(SIZE);
    checks++; if (io_bank !== ~b0) begin errors++; $display("FAIL drop1 io_bank got %b exp %b", io_bank, ~b0); end
    strobe_n(SIZE);
    checks++; if (io_bank !== b0) begin errors++; $display("FAIL drop2 io_bank got %b exp %b", io_bank, b0); end
    checks++; if (pulses_seen != 0) begin errors++; $display("FAIL drop pulses got %0d exp 0", pulses_seen); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL drop overrun got %b exp 1", overrun); end
    checks++; if (drop_count !== 3'd2) begin errors++; $display("FAIL drop drop_count got %0d exp 2", drop_count); end
    checks++; if (proc_busy !== 1'b1) begin errors++; $display("FAIL drop proc_busy got %b exp 1", proc_busy); end
  endtask

  task automatic test_coincident_done;
    tick(0, 1, 0, 0, 1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clear overrun got %b exp 0", overrun); end
    strobe_n(SIZE - 1);
    tick(0, 1, 1, 1, 0);
    checks++; if (chunk_pulse !== 1'b1) begin errors++; $display("FAIL coincident chunk_pulse got %b exp 1", chunk_pulse); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coincident overrun got %b exp 0", overrun); end
    checks++; if (chunk_count !== 16'd3) begin errors++; $display("FAIL coincident chunk_count got %0d exp 3", chunk_count); end
    checks++; if (proc_busy !== 1'b1) begin errors++; $display("FAIL coincident proc_busy got %b exp 1", proc_busy); end
    tick(0, 1, 0, 0, 0);
    checks++; if (chunk_pulse !== 1'b0) begin errors++; $display("FAIL coincident pulse_width got %b exp 0", chunk_pulse); end
  endtask

  task automatic test_overrun_clear;
    strobe_n(SIZE - 1);
    tick(0, 1, 1, 0, 1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL set_wins overrun got %b exp 1", overrun); end
    checks++; if (drop_count !== 3'd3) begin errors++; $display("FAIL set_wins drop_count got %0d exp 3", drop_count); end
    tick(0, 1, 0, 0, 1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clear_alone overrun got %b exp 0", overrun); end
  endtask

  task automatic test_drop_saturate;
    strobe_n(SIZE * 6);
    checks++; if (drop_count !== 3'(DROP_MAX)) begin errors++; $display("FAIL saturate drop_count got %0d exp %0d", drop_count, DROP_MAX); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL saturate overrun got %b exp 1", overrun); end
  endtask

  task automatic test_disable_and_reset;
    tick(0, 1, 0, 1, 0);
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL release proc_busy got %b exp 0", proc_busy); end
    pulses_seen = 0;
    strobe_n(5);
    checks++; if (io_ptr !== 3'd5) begin errors++; $display("FAIL pre_disable io_ptr got %0d exp 5", io_ptr); end
    tick(0, 0, 1, 0, 0);
    checks++; if (io_ptr !== '0) begin errors++; $display("FAIL disable io_ptr got %0d exp 0", io_ptr); end
    checks++; if (io_bank !== 1'b0) begin errors++; $display("FAIL disable io_bank got %b exp 0", io_bank); end
    tick(0, 1, 0, 0, 0);
    strobe_n(3);
    checks++; if (io_ptr !== 3'd3) begin errors++; $display("FAIL reenable io_ptr got %0d exp 3", io_ptr); end
    tick(1, 1, 1, 1, 0);
    checks++; if (io_ptr !== '0) begin errors++; $display("FAIL midrst io_ptr got %0d exp 0", io_ptr); end
    checks++; if (io_bank !== 1'b0) begin errors++; $display("FAIL midrst io_bank got %b exp 0", io_bank); end
    checks++; if (chunk_count !== 16'd0) begin errors++; $display("FAIL midrst chunk_count got %0d exp 0", chunk_count); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL midrst drop_count got %0d exp 0", drop_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst overrun got %b exp 0", overrun); end
    tick(0, 1, 0, 1, 0);
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL stale_done proc_busy got %b exp 0", proc_busy); end
    checks++; if (pulses_seen != 0) begin errors++; $display("FAIL disable_rst pulses got %0d exp 0", pulses_seen); end
  endtask

  task automatic test_random;
    bit r, en, st, dn, oc;
    tick(1, 0, 0, 0, 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r  = ($urandom_range(0, 999) == 0);
      en = ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 1) == 1);
      dn = ($urandom_range(0, 9) == 0);
      oc = ($urandom_range(0, 29) == 0);
      tick(r, en, st, dn, oc);
      checks++; if (io_ptr !== PW'(m_ptr)) begin errors++; $display("FAIL rand io_ptr cyc %0d got %0d exp %0d", cyc, io_ptr, m_ptr); end
      checks++; if (io_bank !== 1'(m_bank)) begin errors++; $display("FAIL rand io_bank cyc %0d got %b exp %0d", cyc, io_bank, m_bank); end
      checks++; if (proc_bank !== 1'(1 - m_bank)) begin errors++; $display("FAIL rand proc_bank cyc %0d got %b exp %0d", cyc, proc_bank, 1 - m_bank); end
      checks++; if (chunk_pulse !== 1'(m_pulse)) begin errors++; $display("FAIL rand chunk_pulse cyc %0d got %b exp %0d", cyc, chunk_pulse, m_pulse); end
      checks++; if (proc_busy !== 1'(m_busy)) begin errors++; $display("FAIL rand proc_busy cyc %0d got %b exp %0d", cyc, proc_busy, m_busy); end
      checks++; if (overrun !== 1'(m_ovr)) begin errors++; $display("FAIL rand overrun cyc %0d got %b exp %0d", cyc, overrun, m_ovr); end
      checks++; if (chunk_count !== 16'(m_cc)) begin errors++; $display("FAIL rand chunk_count cyc %0d got %0d exp %0d", cyc, chunk_count, m_cc); end
      checks++; if (drop_count !== DW'(m_dc)) begin errors++; $display("FAIL rand drop_count cyc %0d got %0d exp %0d", cyc, drop_count, m_dc); end
    end
  endtask

  initial begin
    test_reset();
    test_first_chunk();
    test_done_then_chunk();
    test_overrun();
    test_coincident_done();
    test_overrun_clear();
    test_drop_saturate();
    test_disable_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chunk_scheduler.md
CHUNK_SCHEDULER -- requirements
Module: chunk_scheduler

Interface
REQ-001 SHALL have parameter IO_BUFF_SIZE, default 64, samples per chunk (power of two, >=4).
REQ-002 SHALL have parameter IO_BUFF_PTR_BITS, default $clog2(IO_BUFF_SIZE), sample index width.
REQ-003 SHALL have parameter DROP_CNT_BITS, default 8, dropped-chunk counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port enable  input  1  streaming enable, level.
REQ-007 SHALL have port sample_strobe  input  1  one-cycle pulse per audio sample period.
REQ-008 SHALL have port io_ptr  output  IO_BUFF_PTR_BITS  sample index for the codec side, shared by capture write and playback read.
REQ-009 SHALL have port io_bank  output  1  buffer bank owned by the codec side.
REQ-010 SHALL have port proc_bank  output  1  buffer bank owned by the processor, always ~io_bank.
REQ-011 SHALL have port chunk_pulse  output  1  one-cycle start pulse to simple_processor.
REQ-012 SHALL have port proc_done  input  1  one-cycle pulse when the processor finishes a chunk.
REQ-013 SHALL have port proc_busy  output  1  a chunk was issued and not yet completed.
REQ-014 SHALL have port overrun  output  1  sticky: a chunk boundary arrived while proc_busy.
REQ-015 SHALL have port overrun_clear  input  1  one-cycle clear of overrun.
REQ-016 SHALL have port chunk_count  output  16  chunks issued, wrapping.
REQ-017 SHALL have port drop_count  output  DROP_CNT_BITS  chunks dropped, saturating.

Function
REQ-018 SHALL implement states IDLE, PRIME and STREAM, all outputs registered.
REQ-019 IDLE SHALL ignore sample_strobe and SHALL move to PRIME on the first cycle enable=1.
REQ-020 In PRIME/STREAM, each sample_strobe SHALL increment io_ptr by 1 on the next edge.
REQ-021 A strobe at io_ptr=IO_BUFF_SIZE-1 (the "boundary") SHALL wrap io_ptr to 0 and toggle io_bank/proc_bank on the same edge.
REQ-022 A boundary in PRIME SHALL go to STREAM without chunk_pulse, because the processor bank holds no data yet.
REQ-023 A boundary in STREAM with proc_busy=0 after REQ-025 SHALL assert chunk_pulse for exactly the one cycle in which the new bank value first appears.
REQ-024 The same boundary SHALL set proc_busy and increment chunk_count by 1, wrapping 0xFFFF->0.
REQ-025 proc_done with proc_busy=1 SHALL clear proc_busy; proc_done coincident with a boundary SHALL be applied first, giving no overrun.
REQ-026 A boundary in STREAM with proc_busy=1 SHALL suppress chunk_pulse, keep proc_busy=1, set overrun and increment drop_count, saturating at all-ones.
REQ-027 The bank SHALL still toggle on a dropped boundary so that codec timing is never stalled.
REQ-028 proc_done with proc_busy=0 SHALL be ignored.
REQ-029 overrun_clear SHALL clear overrun; a simultaneous set SHALL win.
REQ-030 enable=0 in any state SHALL force IDLE on the next edge with io_ptr=0 and io_bank=0.
REQ-031 proc_busy SHALL continue to track proc_done while IDLE, and a re-enable SHALL restart in PRIME.
REQ-032 chunk_pulse SHALL never be asserted in IDLE or PRIME.

Reset
REQ-033 rst SHALL force state=IDLE, io_ptr=0, io_bank=0 (proc_bank=1), chunk_pulse=0, proc_busy=0, overrun=0, chunk_count=0 and drop_count=0.
REQ-034 rst SHALL take priority over every other input, including mid-chunk, and an outstanding proc_done afterwards SHALL be ignored (REQ-028).

Structure
REQ-035 The shared audio package SHALL hold the state encodings, the default IO_BUFF_SIZE and the chunk-count width.
REQ-036 The saturating drop counter SHALL be one sub-module, sat_counter (parameter WIDTH; inputs inc and clr).
REQ-037 All other logic SHALL be inline, with a single next-state block and a single register block.

Verification (IO_BUFF_SIZE=8)
REQ-038 Reset, enable=1, 8 strobes -> no chunk_pulse, io_bank 0->1, io_ptr=0; 8 more strobes -> chunk_pulse once, coincident with io_bank=0, chunk_count=1, proc_busy=1.
REQ-039 proc_done 3 cycles after chunk_pulse, then the next boundary -> proc_busy 1->0, chunk_pulse issued, chunk_count=2, overrun=0.
REQ-040 No proc_done across 2 boundaries -> no chunk_pulse, overrun=1, drop_count=2, bank still toggles each boundary.
REQ-041 proc_done in the same cycle as the boundary strobe -> chunk_pulse issued, overrun stays 0.
REQ-042 overrun_clear coincident with a dropped boundary -> overrun remains 1; a later clear alone -> overrun=0.
REQ-043 enable=0 at io_ptr=5, then rst at io_ptr=3 after re-enable -> IDLE with io_ptr=0 and io_bank=0 each time, all counters 0 after rst, no chunk_pulse.
